// File: rtl/ioctl_text_feeder_if.sv
// Handshake bundle between hps_io (download side), the text feeder and the
// ACIA receive path (character side).
interface ioctl_text_feeder_if;
    logic       ioctl_download;
    logic       ioctl_wr;
    logic [7:0] ioctl_data;
    logic       ioctl_wait;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    // master: the host / download + consumer side
    modport master (
        output ioctl_download, ioctl_wr, ioctl_data, out_ready,
        input  ioctl_wait, out_data, out_valid
    );

    // slave: the feeder itself
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_data, out_ready,
        output ioctl_wait, out_data, out_valid
    );
endinterface

// File: rtl/ioctl_text_feeder.sv
// Buffers ioctl download bytes in a small FIFO, rewrites line endings / case,
// and paces characters into the ACIA receive path with idle gaps.
module ioctl_text_feeder #(
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 2,
    parameter int CNT_W        = 24,
    parameter int CHAR_GAP     = 50000,
    parameter int LINE_GAP     = 2500000
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable_i,
    input  logic [1:0]            eol_mode_i,
    ioctl_text_feeder_if.slave    bus,
    output logic                  busy_o,
    output logic                  overflow_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_CNT = (DEPTH_LOG2+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0]    CHAR_GAP_C = CNT_W'(CHAR_GAP);
    localparam logic [CNT_W-1:0]    LINE_GAP_C = CNT_W'(LINE_GAP);

    typedef enum logic [1:0] {ST_IDLE, ST_PRESENT, ST_GAP} state_t;

    state_t                state_q;
    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [CNT_W-1:0]      gap_q;
    logic [7:0]            out_data_q;
    logic                  out_valid_q;
    logic                  wait_q;
    logic                  overflow_q;
    logic                  download_q;

    logic [7:0] byte_f;
    logic       drop, accept, wr_req, pop, full, do_write, lost;

    always_comb begin
        byte_f = bus.ioctl_data;
        drop   = 1'b0;
        if (bus.ioctl_data == 8'h1A) begin
            drop = 1'b1;
        end else if (bus.ioctl_data == 8'h0A) begin
            if (eol_mode_i == 2'd1)
                byte_f = 8'h0D;
            else if (eol_mode_i[1])
                drop = 1'b1;
        end else if (eol_mode_i == 2'd3 && bus.ioctl_data >= 8'h61 && bus.ioctl_data <= 8'h7A) begin
            byte_f = bus.ioctl_data & 8'hDF;
        end
    end

    assign accept   = bus.ioctl_wr & bus.ioctl_download & enable_i;
    assign wr_req   = accept & ~drop;
    assign pop      = enable_i & (state_q == ST_PRESENT) & out_valid_q & bus.out_ready;
    assign full     = (count_q == FULL_CNT);
    // A simultaneous pop frees the slot, so a full FIFO still takes the byte.
    assign do_write = wr_req & (~full | pop);
    assign lost     = wr_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (!enable_i)
            count_d = '0;
        else if (do_write && !pop)
            count_d = count_q + (DEPTH_LOG2+1)'(1);
        else if (pop && !do_write)
            count_d = count_q - (DEPTH_LOG2+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_write)
            mem_q[wr_ptr_q] <= byte_f;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= 1'b0;
            overflow_q <= 1'b0;
            download_q <= 1'b0;
        end else begin
            download_q <= bus.ioctl_download;
            count_q    <= count_d;
            wait_q     <= (count_d >= AFULL_CNT);
            if (lost)
                overflow_q <= 1'b1;
            else if (bus.ioctl_download && !download_q)
                overflow_q <= 1'b0;
            if (!enable_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_write) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
                if (pop)      rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            gap_q       <= '0;
        end else if (!enable_i) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != '0) begin
                        out_data_q  <= mem_q[rd_ptr_q];
                        out_valid_q <= 1'b1;
                        state_q     <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        gap_q       <= (out_data_q == 8'h0D) ? LINE_GAP_C : CHAR_GAP_C;
                        state_q     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q == '0)
                        state_q <= ST_IDLE;
                    else
                        gap_q <= gap_q - CNT_W'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign overflow_o     = overflow_q;
    assign busy_o         = (count_q != '0) | (state_q != ST_IDLE) | bus.ioctl_download;
endmodule
